// File: rtl/reg_select_bank.sv
// Register-select decoder and sixteen 32-bit general registers for the datapath bus.
// Optional feature macro: BAOUT_ZERO_EN (adds BAout and base-zero reads of R0).
module reg_select_bank (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
`ifdef BAOUT_ZERO_EN
  input  logic        BAout,
`endif
  input  logic [31:0] BusMuxOut,
  output logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  output logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  output logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  output logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  output logic [31:0] BusMuxInR0,  BusMuxInR1,  BusMuxInR2,  BusMuxInR3,
  output logic [31:0] BusMuxInR4,  BusMuxInR5,  BusMuxInR6,  BusMuxInR7,
  output logic [31:0] BusMuxInR8,  BusMuxInR9,  BusMuxInR10, BusMuxInR11,
  output logic [31:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
  output logic [31:0] C_sign_extended,
  output logic        sel_err
);

  function automatic logic signed [31:0] signExtend19(input logic [18:0] imm);
    return {{13{imm[18]}}, imm};
  endfunction

  logic [3:0]  selField;
  logic        hasSel;
  logic        driveEn;
  logic        multiSel;
  logic [15:0] loadVec;
  logic [15:0] driveVec;
  logic [31:0] regFile [16];

`ifdef BAOUT_ZERO_EN
  assign driveEn = Rout | BAout;
`else
  assign driveEn = Rout;
`endif

  // Priority field select: Ra over Rb over Rc
  always_comb begin
    selField = 4'd0;
    if (Gra)      selField = IR[26:23];
    else if (Grb) selField = IR[22:19];
    else if (Grc) selField = IR[18:15];
  end

  assign hasSel   = Gra | Grb | Grc;
  assign multiSel = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
  assign loadVec  = (Rin & hasSel)     ? (16'h0001 << selField) : 16'h0000;
  assign driveVec = (driveEn & hasSel) ? (16'h0001 << selField) : 16'h0000;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) regFile[i] <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < 16; i++)
        if (loadVec[i]) regFile[i] <= BusMuxOut;
    end
  end

  // Sticky flag for ambiguous multi-field selection while a strobe is requested
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                            sel_err <= 1'b0;
    else if (multiSel & (Rin | driveEn))  sel_err <= 1'b1;
  end

  assign C_sign_extended = signExtend19(IR[18:0]);

  assign {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
          R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in} = loadVec;
  assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
          R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out} = driveVec;

`ifdef BAOUT_ZERO_EN
  // Base-address drive of R0 reads as zero for base-zero addressing
  assign BusMuxInR0 = (BAout & hasSel & (selField == 4'd0)) ? 32'h0000_0000 : regFile[0];
`else
  assign BusMuxInR0 = regFile[0];
`endif
  assign BusMuxInR1  = regFile[1];
  assign BusMuxInR2  = regFile[2];
  assign BusMuxInR3  = regFile[3];
  assign BusMuxInR4  = regFile[4];
  assign BusMuxInR5  = regFile[5];
  assign BusMuxInR6  = regFile[6];
  assign BusMuxInR7  = regFile[7];
  assign BusMuxInR8  = regFile[8];
  assign BusMuxInR9  = regFile[9];
  assign BusMuxInR10 = regFile[10];
  assign BusMuxInR11 = regFile[11];
  assign BusMuxInR12 = regFile[12];
  assign BusMuxInR13 = regFile[13];
  assign BusMuxInR14 = regFile[14];
  assign BusMuxInR15 = regFile[15];

endmodule

// File: tb/tb_reg_select_bank.sv
// Directed self-checking bench for reg_select_bank (default build or BAOUT_ZERO_EN).
module tb_reg_select_bank;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        Gra, Grb, Grc, Rin, Rout;
`ifdef BAOUT_ZERO_EN
  logic        BAout;
`endif
  logic [31:0] BusMuxOut;
  wire  [15:0] rIn;
  wire  [15:0] rOut;
  wire  [15:0][31:0] busIn;
  wire  [31:0] cSext;
  wire         selErr;

  int checks = 0;
  int errors = 0;
  logic [31:0] expReg [16];

  always #5 clock = ~clock;

  reg_select_bank dut (
    .clock(clock), .clear(clear), .IR(IR),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
`ifdef BAOUT_ZERO_EN
    .BAout(BAout),
`endif
    .BusMuxOut(BusMuxOut),
    .R0in(rIn[0]),   .R1in(rIn[1]),   .R2in(rIn[2]),   .R3in(rIn[3]),
    .R4in(rIn[4]),   .R5in(rIn[5]),   .R6in(rIn[6]),   .R7in(rIn[7]),
    .R8in(rIn[8]),   .R9in(rIn[9]),   .R10in(rIn[10]), .R11in(rIn[11]),
    .R12in(rIn[12]), .R13in(rIn[13]), .R14in(rIn[14]), .R15in(rIn[15]),
    .R0out(rOut[0]),   .R1out(rOut[1]),   .R2out(rOut[2]),   .R3out(rOut[3]),
    .R4out(rOut[4]),   .R5out(rOut[5]),   .R6out(rOut[6]),   .R7out(rOut[7]),
    .R8out(rOut[8]),   .R9out(rOut[9]),   .R10out(rOut[10]), .R11out(rOut[11]),
    .R12out(rOut[12]), .R13out(rOut[13]), .R14out(rOut[14]), .R15out(rOut[15]),
    .BusMuxInR0(busIn[0]),   .BusMuxInR1(busIn[1]),   .BusMuxInR2(busIn[2]),
    .BusMuxInR3(busIn[3]),   .BusMuxInR4(busIn[4]),   .BusMuxInR5(busIn[5]),
    .BusMuxInR6(busIn[6]),   .BusMuxInR7(busIn[7]),   .BusMuxInR8(busIn[8]),
    .BusMuxInR9(busIn[9]),   .BusMuxInR10(busIn[10]), .BusMuxInR11(busIn[11]),
    .BusMuxInR12(busIn[12]), .BusMuxInR13(busIn[13]), .BusMuxInR14(busIn[14]),
    .BusMuxInR15(busIn[15]),
    .C_sign_extended(cSext), .sel_err(selErr)
  );

  function automatic logic [31:0] mkIR(input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [3:0] rc);
    return {5'b0, ra, rb, rc, 15'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_R%0d", tag, i), busIn[i], expReg[i]);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) expReg[i] = 32'h0;
  endtask

  initial begin
    clear = 1'b1; IR = 32'h0; BusMuxOut = 32'h0;
    Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0;
`ifdef BAOUT_ZERO_EN
    BAout = 0;
`endif
    clearModel();
    tick();
    checkAll("reset");
    chk("reset_selErr", {31'b0, selErr}, 32'h0);
    chk("reset_rIn", {16'b0, rIn}, 32'h0);
    chk("reset_rOut", {16'b0, rOut}, 32'h0);

    // Load R5
    clear = 0;
    IR = mkIR(4'd5, 4'd0, 4'd0); Gra = 1; Rin = 1; BusMuxOut = 32'h1234_5678;
    #1 chk("r5_rIn", {16'b0, rIn}, 32'h0000_0020);
    tick(); expReg[5] = 32'h1234_5678;
    checkAll("r5_write");

    // Priority Ra over Rb, with sticky selection error
    Rin = 0; Gra = 1; Grb = 1; Rout = 1; IR = mkIR(4'd2, 4'd9, 4'd0);
    #1 chk("prio_rOut", {16'b0, rOut}, 32'h0000_0004);
    chk("prio_rIn", {16'b0, rIn}, 32'h0);
    chk("prio_selErr_pre", {31'b0, selErr}, 32'h0);
    tick();
    chk("prio_selErr_set", {31'b0, selErr}, 32'h1);
    Gra = 0; Grb = 0; Rout = 0;
    tick();
    chk("prio_selErr_held", {31'b0, selErr}, 32'h1);
    checkAll("prio_regs");

    // Asynchronous clear between edges
    #2 clear = 1;
    #1 clearModel();
    chk("aclr_R5", busIn[5], 32'h0);
    chk("aclr_selErr", {31'b0, selErr}, 32'h0);
    Gra = 1; IR = mkIR(4'd4, 4'd0, 4'd0); Rin = 1; BusMuxOut = 32'hFFFF_FFFF;
    #1 chk("clr_decode_live", {16'b0, rIn}, 32'h0000_0010);
    tick();
    chk("clr_write_blocked", busIn[4], 32'h0);
    clear = 0; Gra = 0; Rin = 0;

    // Write/decode R7
    IR = mkIR(4'd7, 4'd0, 4'd0); Gra = 1; Rin = 1; BusMuxOut = 32'hDEAD_BEEF;
    #1 chk("r7_rIn", {16'b0, rIn}, 32'h0000_0080);
    chk("r7_rOut", {16'b0, rOut}, 32'h0);
    tick(); expReg[7] = 32'hDEAD_BEEF;
    checkAll("r7_write");

    // Read during write on R3
    Gra = 0; Grc = 1; IR = mkIR(4'd0, 4'd0, 4'd3); Rin = 1; BusMuxOut = 32'h1;
    tick(); expReg[3] = 32'h1;
    Rout = 1; BusMuxOut = 32'h2;
    #1 chk("rdw_rOut", {16'b0, rOut}, 32'h0000_0008);
    chk("rdw_rIn", {16'b0, rIn}, 32'h0000_0008);
    chk("rdw_old", busIn[3], 32'h1);
    tick(); expReg[3] = 32'h2;
    checkAll("rdw_new");

    // No field selected: no strobes, no writes
    Grc = 0; Rin = 1; Rout = 1; BusMuxOut = 32'h0000_CAFE;
    #1 chk("nosel_rIn", {16'b0, rIn}, 32'h0);
    chk("nosel_rOut", {16'b0, rOut}, 32'h0);
    tick();
    checkAll("nosel_regs");
    chk("nosel_selErr", {31'b0, selErr}, 32'h0);

    // Multiple fields without any strobe must not flag
    Rin = 0; Rout = 0; Gra = 1; Grb = 1;
    tick();
    chk("multi_idle_selErr", {31'b0, selErr}, 32'h0);

    // Rb over Rc, with flag
    Gra = 0; Grb = 1; Grc = 1; IR = mkIR(4'd0, 4'd10, 4'd11); Rin = 1;
    BusMuxOut = 32'h0BAD_F00D;
    #1 chk("prio_bc_rIn", {16'b0, rIn}, 32'h0000_0400);
    tick(); expReg[10] = 32'h0BAD_F00D;
    checkAll("prio_bc_regs");
    chk("prio_bc_selErr", {31'b0, selErr}, 32'h1);
    Grb = 0; Grc = 0; Rin = 0;

    // Sign extension
    IR = 32'h0004_0000;
    #1 chk("sext_neg", cSext, 32'hFFFC_0000);
    IR = 32'h0003_FFFF;
    #1 chk("sext_pos", cSext, 32'h0003_FFFF);
    IR = 32'hFFF8_0000;
    #1 chk("sext_upper_ignored", cSext, 32'h0);

    // Clear during a write cycle loses the write
    Gra = 1; IR = mkIR(4'd6, 4'd0, 4'd0); Rin = 1; BusMuxOut = 32'h55;
    #1 clear = 1;
    tick(); clearModel();
    checkAll("clr_during_write");
    chk("clr_during_write_selErr", {31'b0, selErr}, 32'h0);
    clear = 0; Gra = 0; Rin = 0;

`ifdef BAOUT_ZERO_EN
    // Base-zero addressing through R0
    Gra = 1; IR = mkIR(4'd0, 4'd0, 4'd0); Rin = 1; BusMuxOut = 32'hAAAA_5555;
    tick(); Rin = 0; BAout = 1;
    #1 chk("bz_R0_zero", busIn[0], 32'h0);
    chk("bz_rOut", {16'b0, rOut}, 32'h0000_0001);
    BAout = 0; Rout = 1;
    #1 chk("bz_rout_real", busIn[0], 32'hAAAA_5555);
    chk("bz_rout_rOut", {16'b0, rOut}, 32'h0000_0001);
    Rout = 0; BAout = 1; IR = mkIR(4'd1, 4'd0, 4'd0);
    #1 chk("bz_other_sel", busIn[0], 32'hAAAA_5555);
    chk("bz_other_rOut", {16'b0, rOut}, 32'h0000_0002);
    BAout = 0; Gra = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
